calc_arbiter: RTL and testbench

//  Shares one calculator datapath (calc control unit plus register file/ALU) between two

---
 rtl/calc_arbiter.sv | 159 +++++++++++++++
 tb/tb_calc_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin arbiter sharing one calculator between two
// requesters. Latches the winner's opcode/operands, pulses go, waits for
// done_calc (bounded by a watchdog) and returns the result with an ack.
module calc_arbiter #(
  parameter int DW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [1:0]    op0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  input  logic          req1,
  input  logic [1:0]    op1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] res_out,
  output logic          err,
  output logic          go,
  output logic [1:0]    op,
  output logic [DW-1:0] in_a,
  output logic [DW-1:0] in_b,
  input  logic          done_calc,
  input  logic [DW-1:0] result,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DW-1:0] res_q, res_d;
  logic          err_q, err_d;
  logic          go_q, go_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic          pick1;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port below is driven straight from a register.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    res_d   = res_q;
    err_d   = err_q;
    go_d    = 1'b0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    pick1   = req1 & (~req0 | ~last_q);
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          last_d  = pick1;
          op_d    = pick1 ? op1 : op0;
          a_d     = pick1 ? a1  : a0;
          b_d     = pick1 ? b1  : b0;
          go_d    = 1'b1;
          res_d   = '0;
          err_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (done_calc) begin
          res_d   = result;
          err_d   = 1'b0;
          ack0_d  = gnt0_q;
          ack1_d  = gnt1_q;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          ack0_d  = gnt0_q;
          ack1_d  = gnt1_q;
          state_d = RESP;
        end
      end
      RESP: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        res_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      res_q   <= res_d;
      err_q   <= err_d;
      go_q    <= go_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign res_out = res_q;
  assign err     = err_q;
  assign go      = go_q;
  assign op      = op_q;
  assign in_a    = a_q;
  assign in_b    = b_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed testbench for calc_arbiter with hand-computed expectations.
module tb_calc_arbiter;
  localparam int DW      = 4;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [1:0]    op0 = '0, op1 = '0;
  logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          gnt0, gnt1, ack0, ack1, err, go, busy;
  logic [DW-1:0] res_out, in_a, in_b;
  logic [1:0]    op;
  logic          done_calc = 1'b0;
  logic [DW-1:0] result = '0;

  int total = 0;
  int bad   = 0;
  int go_cnt = 0, gnt1_cnt = 0, overlap_cnt = 0;
  int snap_go, snap_g1;

  calc_arbiter #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .res_out(res_out), .err(err), .go(go), .op(op),
    .in_a(in_a), .in_b(in_b), .done_calc(done_calc),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (go) go_cnt <= go_cnt + 1;
    if (gnt1) gnt1_cnt <= gnt1_cnt + 1;
    if (gnt0 && gnt1) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {11'b0, gnt0, gnt1, ack0, ack1, res_out, err, go, op, in_a, in_b, busy};
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    tick;
    tick;
    chk({tag, "_rst_outs"}, outs(), 32'h0);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant, then completes the op after dly WAIT cycles.
  task automatic run_op(input string tag, input int who, input logic [1:0] eop,
                        input logic [DW-1:0] ea, input int dly, input logic [DW-1:0] res);
    int n = 0;
    while (!(gnt0 || gnt1) && n < 8) begin
      tick;
      n++;
    end
    chk({tag, "_gnt_seen"}, {31'b0, gnt0 | gnt1}, 1);
    chk({tag, "_who"}, {31'b0, gnt1}, who);
    chk({tag, "_go"}, {31'b0, go}, 1);
    chk({tag, "_op"}, {30'b0, op}, {30'b0, eop});
    chk({tag, "_in_a"}, {28'b0, in_a}, {28'b0, ea});
    tick;
    repeat (dly) tick;
    chk({tag, "_go_low"}, {31'b0, go}, 0);
    done_calc = 1'b1;
    result    = res;
    tick;
    done_calc = 1'b0;
    chk({tag, "_ack"}, {30'b0, ack1, ack0}, (who == 1) ? 32'd2 : 32'd1);
    chk({tag, "_res"}, {28'b0, res_out}, {28'b0, res});
    chk({tag, "_err"}, {31'b0, err}, 0);
    tick;
    chk({tag, "_idle"}, {29'b0, busy, ack0, ack1}, 0);
  endtask

  initial begin
    // 1: single request, done one cycle after go
    do_reset("t1");
    snap_go = go_cnt;
    snap_g1 = gnt1_cnt;
    req0 = 1'b1; op0 = 2'b00; a0 = 4'd3; b0 = 4'd4;
    run_op("t1", 0, 2'b00, 4'd3, 0, 4'd7);
    req0 = 1'b0;
    chk("t1_go_once", go_cnt - snap_go, 1);
    chk("t1_no_gnt1", gnt1_cnt - snap_g1, 0);

    // 2: both requesting from reset, grants alternate
    req0 = 1'b1; op0 = 2'b01; a0 = 4'h2; b0 = 4'h1;
    req1 = 1'b1; op1 = 2'b10; a1 = 4'hA; b1 = 4'h5;
    do_reset("t2");
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_op("t2_r0", 0, 2'b01, 4'h2, i % 3, 4'(i + 1));
      else            run_op("t2_r1", 1, 2'b10, 4'hA, i % 3, 4'(i + 1));
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // 3: watchdog timeout on requester 1, then a normal op
    req1 = 1'b1; op1 = 2'b11; a1 = 4'h5; b1 = 4'h6; result = 4'hF;
    tick;
    chk("t3_gnt1", {31'b0, gnt1}, 1);
    tick;
    repeat (TIMEOUT - 1) tick;
    chk("t3_not_early", {31'b0, ack1}, 0);
    tick;
    chk("t3_ack1", {31'b0, ack1}, 1);
    chk("t3_err", {31'b0, err}, 1);
    chk("t3_res0", {28'b0, res_out}, 0);
    tick;
    chk("t3_idle", {31'b0, busy}, 0);
    run_op("t3_next", 1, 2'b11, 4'h5, 2, 4'hC);
    req1 = 1'b0;

    // 4: done_calc outside WAIT is ignored
    req0 = 1'b1; op0 = 2'b10; a0 = 4'h6; b0 = 4'h3;
    done_calc = 1'b1; result = 4'h5;
    tick;
    chk("t4_gnt0", {30'b0, gnt0, go}, 32'd3);
    tick;
    done_calc = 1'b0;
    chk("t4_in_wait", {30'b0, busy, ack0}, 32'd2);
    repeat (3) tick;
    chk("t4_still_wait", {30'b0, busy, ack0}, 32'd2);
    done_calc = 1'b1; result = 4'h2;
    tick;
    done_calc = 1'b0;
    chk("t4_ack0", {31'b0, ack0}, 1);
    chk("t4_res", {28'b0, res_out}, 4'h2);
    req0 = 1'b0;
    tick;

    // 5: reset during WAIT, then tie goes to requester 0
    req0 = 1'b1; a0 = 4'h1; op0 = 2'b00;
    tick;
    chk("t5_gnt0", {31'b0, gnt0}, 1);
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("t5_async_outs", outs(), 32'h0);
    req1 = 1'b1; a1 = 4'h8; op1 = 2'b01;
    tick;
    chk("t5_held_outs", outs(), 32'h0);
    rst_n = 1'b1;
    run_op("t5_tie", 0, 2'b00, 4'h1, 1, 4'h3);
    run_op("t5_then1", 1, 2'b01, 4'h8, 0, 4'h4);
    req0 = 1'b0;
    req1 = 1'b0;

    // 6: req0 dropped after grant, inputs not re-sampled
    req0 = 1'b1; op0 = 2'b01; a0 = 4'hD; b0 = 4'h2;
    tick;
    chk("t6_gnt0", {31'b0, gnt0}, 1);
    req0 = 1'b0; a0 = 4'h0;
    tick;
    chk("t6_hold_a", {28'b0, in_a}, 4'hD);
    chk("t6_hold_gnt", {31'b0, gnt0}, 1);
    done_calc = 1'b1; result = 4'd9;
    tick;
    done_calc = 1'b0;
    chk("t6_ack0", {31'b0, ack0}, 1);
    chk("t6_res", {28'b0, res_out}, 4'd9);
    tick;
    chk("t6_idle", {30'b0, busy, gnt0}, 0);

    chk("mutex", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
